arbitro_cdb: RTL and testbench
==============================

Name: arbitro_cdb

Overview:
- Round-robin arbiter and registered driver for the Common Data Bus (CDB) in the Tomasulo datapath.
- Functional units that have finished executing a reservation-station instruction raise a request carrying a result tag and a 16-bit value.
- Each cycle the block grants at most one unit and broadcasts its tag/value to the reservation stations, the register file and the dispatch unit, so that Busy bits and operand tags can be released.

Parameters:
N_FU, 4, number of requesting functional units (2..8)
TAG_W, 3, width of reservation-station tag; tag 0 is reserved as "no tag"
DATA_W, 16, width of broadcast result value

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Req  input  N_FU  per-unit broadcast request, level, held until granted
Tag_In  input  N_FU*TAG_W  packed tags, unit i at bits [i*TAG_W +: TAG_W]
Dado_In  input  N_FU*DATA_W  packed results, unit i at bits [i*DATA_W +: DATA_W]
Stall  input  1  CDB consumer cannot accept a broadcast this cycle
Flush  input  1  squash: cancel any broadcast being issued
Grant  output  N_FU  registered one-hot grant pulse, aligned with CDB_Valido
CDB_Valido  output  1  registered: CDB carries a valid result this cycle
CDB_Tag  output  TAG_W  registered broadcast tag
CDB_Dado  output  DATA_W  registered broadcast value
Contador_Broadcast  output  16  number of broadcasts issued since reset, wraps

Behaviour:
- Reset is synchronous and active-high. At a rising Clock edge with Reset=1: Grant=0, CDB_Valido=0, CDB_Tag=0, CDB_Dado=0, Contador_Broadcast=0, internal pointer Ptr=0. Reset overrides Flush, Stall and Req. Reset during an active broadcast drops it with no partial state.
- Eligible set at edge k: E = Req & ~Grant, where Grant is the current registered value. A unit granted in cycle k is therefore never re-granted at the edge ending cycle k, even if its Req is still high. A requester must drop Req, or present a new result, in the cycle after it sees Grant.
- Selection is round-robin. Among E, the winner w is the first set bit scanning Ptr, Ptr+1, …, N_FU-1, 0, …, Ptr-1.
- Normal edge (Reset=0, Flush=0, Stall=0, E≠0):
  - Grant <= one-hot(w)
  - CDB_Valido <= 1
  - CDB_Tag <= Tag_In[w]
  - CDB_Dado <= Dado_In[w]
  - Ptr <= (w+1) mod N_FU
  - Contador_Broadcast <= Contador_Broadcast+1, wrapping 0xFFFF to 0x0000
- Idle edge (E=0): Grant<=0, CDB_Valido<=0. CDB_Tag and CDB_Dado hold their previous values; consumers must qualify them with CDB_Valido. Ptr unchanged.
- Stall=1 (Reset=0, Flush=0): Grant<=0, CDB_Valido<=0, Ptr and counter unchanged. Pending Req stay pending and are arbitrated on the first edge with Stall=0.
- Flush=1 (Reset=0): same as Stall. Flush and Stall together behave as Flush. Requesters are responsible for dropping squashed Req; the arbiter keeps no queue.
- Latency: Req sampled at edge k appears as Grant/CDB_Valido in cycle k+1 (one cycle) when uncontended. Worst case with N_FU units continuously requesting is N_FU cycles.
- Throughput: one broadcast per cycle while E≠0.
- A request with Tag_In = 0 is still broadcast as-is; tag legality is the issuing unit's responsibility.
- Grant is always one-hot or zero, and Grant≠0 if and only if CDB_Valido=1.
- Internal state: Ptr register, Grant register, CDB registers and counter. No other state.

Test Plan:
- Reset: drive Req=4'b1111 with Reset=1 for 2 cycles -> Grant=0, CDB_Valido=0, Contador_Broadcast=0. Release Reset -> first grant goes to unit 0 one cycle later.
- Single request: unit 2 Req=1 with Tag_In[2]=3'd5 and Dado_In[2]=16'hBEEF for one edge, dropped on seeing Grant -> exactly one cycle with Grant=4'b0100, CDB_Tag=5, CDB_Dado=16'hBEEF. Counter increments by 1; next cycle CDB_Valido=0.
- Round-robin fairness: all four Req held high and each dropped after its own grant -> grants in order 0,1,2,3 on four consecutive cycles. Re-raising all from Ptr=0 -> order 0,1,2,3 again. Start with Ptr=2 (after a grant to unit 1) -> order 2,3,0,1.
- Back-to-back same unit: unit 1 holds Req=1 continuously with units 0 and 2 also requesting and Ptr=1 -> grants alternate 1,2,0,1,…; unit 1 is never granted on consecutive cycles.
- Stall and Flush: Stall=1 for 3 cycles with unit 3 requesting -> no Grant and Ptr unchanged. Stall drops -> Grant=4'b1000 next cycle. Flush and Stall asserted together -> CDB_Valido=0.
- Counter wrap: preload via 65535 broadcasts (or force) -> the next broadcast gives Contador_Broadcast=0x0000 while CDB_Valido=1.

Source files
------------

// File: rtl/arbitro_cdb_if.sv
// rtl/arbitro_cdb_if.sv - CDB arbitration bus between functional units and the arbiter
interface arbitro_cdb_if #(
  parameter int N_FU   = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
);
  logic [N_FU-1:0]        Req;
  logic [N_FU*TAG_W-1:0]  Tag_In;
  logic [N_FU*DATA_W-1:0] Dado_In;
  logic                   Stall;
  logic                   Flush;
  logic [N_FU-1:0]        Grant;
  logic                   CDB_Valido;
  logic [TAG_W-1:0]       CDB_Tag;
  logic [DATA_W-1:0]      CDB_Dado;
  logic [15:0]            Contador_Broadcast;

  modport master (
    output Req, Tag_In, Dado_In, Stall, Flush,
    input  Grant, CDB_Valido, CDB_Tag, CDB_Dado, Contador_Broadcast
  );

  modport slave (
    input  Req, Tag_In, Dado_In, Stall, Flush,
    output Grant, CDB_Valido, CDB_Tag, CDB_Dado, Contador_Broadcast
  );
endinterface

// File: rtl/arbitro_cdb.sv
// rtl/arbitro_cdb.sv - round-robin Common Data Bus arbiter with registered broadcast
module arbitro_cdb #(
  parameter int N_FU   = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  arbitro_cdb_if.slave  bus
);
  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [N_FU-1:0]   elig;
  logic [PTR_W:0]    cand;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_dado;
  logic [PTR_W-1:0]  ptr_next;

  // The unit holding the bus this cycle sits out the next edge.
  assign elig = bus.Req & ~bus.Grant;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_FU; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_FU)) begin
        cand = cand - (PTR_W+1)'(N_FU);
      end
      if (!found && elig[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_tag  = '0;
    sel_dado = '0;
    for (int i = 0; i < N_FU; i++) begin
      if (win == PTR_W'(i)) begin
        sel_tag  = bus.Tag_In[i*TAG_W +: TAG_W];
        sel_dado = bus.Dado_In[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (win == PTR_W'(N_FU-1)) ? '0 : win + 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr                    <= '0;
      bus.Grant              <= '0;
      bus.CDB_Valido         <= 1'b0;
      bus.CDB_Tag            <= '0;
      bus.CDB_Dado           <= '0;
      bus.Contador_Broadcast <= '0;
    end else if (bus.Flush || bus.Stall || !found) begin
      // Tag/value deliberately hold; consumers qualify with CDB_Valido.
      bus.Grant      <= '0;
      bus.CDB_Valido <= 1'b0;
    end else begin
      bus.Grant              <= N_FU'(1) << win;
      bus.CDB_Valido         <= 1'b1;
      bus.CDB_Tag            <= sel_tag;
      bus.CDB_Dado           <= sel_dado;
      ptr                    <= ptr_next;
      bus.Contador_Broadcast <= bus.Contador_Broadcast + 16'd1;
    end
  end
endmodule

// File: tb/tb_arbitro_cdb.sv
// tb/tb_arbitro_cdb.sv - self-checking bench for arbitro_cdb
module tb_arbitro_cdb;
  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbitro_cdb_if #(.N_FU(N), .TAG_W(TW), .DATA_W(DW)) bus ();

  arbitro_cdb #(.N_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        valid;
    logic [2:0]  tag;
    logic [15:0] dado;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state, expressed as unit indices and plain counts.
  int          m_ptr;
  int          m_last;
  logic        m_valid;
  logic [2:0]  m_tag;
  logic [15:0] m_dado;
  int          m_cnt;

  task automatic add(input logic r, input logic s, input logic f, input logic [3:0] q,
                     input logic [3:0] g, input logic v, input logic [2:0] t,
                     input logic [15:0] d, input logic [15:0] c);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.req = q;
    x.grant = g; x.valid = v; x.tag = t; x.dado = d; x.cnt = c;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      m_ptr = 0; m_last = -1; m_valid = 1'b0; m_tag = '0; m_dado = '0; m_cnt = 0;
    end else if (bus.Stall || bus.Flush) begin
      m_last = -1; m_valid = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && bus.Req[i] && i != m_last) w = i;
      end
      if (w < 0) begin
        m_last = -1; m_valid = 1'b0;
      end else begin
        m_last  = w;
        m_valid = 1'b1;
        m_tag   = bus.Tag_In[w*TW +: TW];
        m_dado  = bus.Dado_In[w*DW +: DW];
        m_ptr   = (w + 1) % N;
        m_cnt   = (m_cnt + 1) % 65536;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tagname);
    logic [3:0] eg;
    eg = (m_last < 0) ? 4'b0 : (4'b1 << m_last);
    check({tagname, " grant"}, 32'(bus.Grant), 32'(eg));
    check({tagname, " valid"}, 32'(bus.CDB_Valido), 32'(m_valid));
    check({tagname, " tag"}, 32'(bus.CDB_Tag), 32'(m_tag));
    check({tagname, " dado"}, 32'(bus.CDB_Dado), 32'(m_dado));
    check({tagname, " cnt"}, 32'(bus.Contador_Broadcast), 32'(m_cnt));
  endtask

  initial begin
    bus.Req = '0; bus.Stall = 1'b0; bus.Flush = 1'b0;
    bus.Tag_In  = {3'd7, 3'd5, 3'd2, 3'd1};
    bus.Dado_In = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};

    add(1,0,0,4'hF, 4'h0,0,3'd0,16'h0000,16'd0);
    add(1,0,0,4'hF, 4'h0,0,3'd0,16'h0000,16'd0);
    add(0,0,0,4'hF, 4'h1,1,3'd1,16'h1111,16'd1);
    add(0,0,0,4'hE, 4'h2,1,3'd2,16'h2222,16'd2);
    add(0,0,0,4'hC, 4'h4,1,3'd5,16'hBEEF,16'd3);
    add(0,0,0,4'h8, 4'h8,1,3'd7,16'h4444,16'd4);
    add(0,0,0,4'h0, 4'h0,0,3'd7,16'h4444,16'd4);
    add(0,0,0,4'h4, 4'h4,1,3'd5,16'hBEEF,16'd5);
    add(0,0,0,4'h0, 4'h0,0,3'd5,16'hBEEF,16'd5);
    add(0,0,0,4'hF, 4'h8,1,3'd7,16'h4444,16'd6);
    add(0,0,0,4'h7, 4'h1,1,3'd1,16'h1111,16'd7);
    add(0,0,0,4'h6, 4'h2,1,3'd2,16'h2222,16'd8);
    add(0,0,0,4'h4, 4'h4,1,3'd5,16'hBEEF,16'd9);
    add(0,0,0,4'h0, 4'h0,0,3'd5,16'hBEEF,16'd9);
    add(0,1,0,4'h8, 4'h0,0,3'd5,16'hBEEF,16'd9);
    add(0,1,0,4'h8, 4'h0,0,3'd5,16'hBEEF,16'd9);
    add(0,1,0,4'h8, 4'h0,0,3'd5,16'hBEEF,16'd9);
    add(0,0,0,4'h8, 4'h8,1,3'd7,16'h4444,16'd10);
    add(0,0,0,4'h0, 4'h0,0,3'd7,16'h4444,16'd10);
    add(0,1,1,4'hF, 4'h0,0,3'd7,16'h4444,16'd10);
    add(0,0,1,4'hF, 4'h0,0,3'd7,16'h4444,16'd10);
    add(0,0,0,4'hF, 4'h1,1,3'd1,16'h1111,16'd11);
    add(0,0,0,4'hF, 4'h2,1,3'd2,16'h2222,16'd12);
    add(0,0,0,4'hF, 4'h4,1,3'd5,16'hBEEF,16'd13);
    add(0,0,0,4'h0, 4'h0,0,3'd5,16'hBEEF,16'd13);
    add(0,0,0,4'h1, 4'h1,1,3'd1,16'h1111,16'd14);
    add(0,0,0,4'h0, 4'h0,0,3'd1,16'h1111,16'd14);
    add(0,0,0,4'h7, 4'h2,1,3'd2,16'h2222,16'd15);
    add(0,0,0,4'h7, 4'h4,1,3'd5,16'hBEEF,16'd16);
    add(0,0,0,4'h7, 4'h1,1,3'd1,16'h1111,16'd17);
    add(0,0,0,4'h7, 4'h2,1,3'd2,16'h2222,16'd18);
    add(0,0,0,4'h0, 4'h0,0,3'd2,16'h2222,16'd18);
    add(0,0,0,4'hF, 4'h4,1,3'd5,16'hBEEF,16'd19);
    add(1,0,0,4'hF, 4'h0,0,3'd0,16'h0000,16'd0);
    add(0,0,0,4'hF, 4'h1,1,3'd1,16'h1111,16'd1);
    add(0,0,0,4'h0, 4'h0,0,3'd1,16'h1111,16'd1);

    foreach (vecs[v]) begin
      rst = vecs[v].rst; bus.Stall = vecs[v].stall; bus.Flush = vecs[v].flush;
      bus.Req = vecs[v].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d grant", v), 32'(bus.Grant), 32'(vecs[v].grant));
      check($sformatf("vec%0d valid", v), 32'(bus.CDB_Valido), 32'(vecs[v].valid));
      check($sformatf("vec%0d tag", v), 32'(bus.CDB_Tag), 32'(vecs[v].tag));
      check($sformatf("vec%0d dado", v), 32'(bus.CDB_Dado), 32'(vecs[v].dado));
      check($sformatf("vec%0d cnt", v), 32'(bus.Contador_Broadcast), 32'(vecs[v].cnt));
    end

    // Randomized traffic against the reference model, starting from reset.
    rst = 1'b1; bus.Req = '0; bus.Stall = 1'b0; bus.Flush = 1'b0;
    tick();
    check_model("rnd reset");
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus.Stall = ($urandom_range(0, 7) == 0);
      bus.Flush = ($urandom_range(0, 9) == 0);
      bus.Req   = 4'($urandom);
      for (int u = 0; u < N; u++) begin
        bus.Tag_In[u*TW +: TW]  = 3'($urandom);
        bus.Dado_In[u*DW +: DW] = 16'($urandom);
      end
      tick();
      check_model($sformatf("rnd%0d", c));
      check($sformatf("rnd%0d onehot", c), 32'($onehot0(bus.Grant)), 32'd1);
      check($sformatf("rnd%0d grant_vs_valid", c), 32'(bus.Grant != 0), 32'(bus.CDB_Valido));
    end

    // Counter wrap: two units requesting continuously give one broadcast per cycle.
    rst = 1'b0; bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Req = 4'b0011;
    for (int c = 0; c < 70000 && m_cnt != 65535; c++) tick();
    check("wrap pre cnt", 32'(bus.Contador_Broadcast), 32'hFFFF);
    tick();
    check("wrap cnt", 32'(bus.Contador_Broadcast), 32'h0000);
    check("wrap valid", 32'(bus.CDB_Valido), 32'd1);
    check_model("wrap");
    bus.Req = '0;
    tick();
    check_model("wrap idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
